// File: rtl/watchdog_timer_multi.sv
// Multi-channel watchdog with a shared tick prescaler, per-channel kick windows,
// one-shot or auto-reload timeouts, and a sticky system reset request.
module watchdog_timer_multi #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned N_CH       = 2,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         start,
    input  logic [N_CH-1:0]         stop,
    input  logic [N_CH-1:0]         kick,
    input  logic [N_CH*WIDTH-1:0]   load,
    input  logic [N_CH*WIDTH-1:0]   preload,
    input  logic [N_CH*WIDTH-1:0]   window,
    input  logic [N_CH-1:0]         win_en,
    input  logic [N_CH-1:0]         auto_reload,
    input  logic [PRESCALE_W-1:0]   prescale,
    input  logic [N_CH-1:0]         timeout_clr,
    output logic [N_CH-1:0]         timeout,
    output logic [N_CH-1:0]         early_kick,
    output logic [N_CH-1:0]         running,
    output logic [N_CH*WIDTH-1:0]   count,
    output logic                    sys_reset_req
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_EXPIRED
    } state_t;

    state_t                 state_q [N_CH];
    state_t                 state_d [N_CH];
    logic [WIDTH-1:0]       cnt_q   [N_CH];
    logic [WIDTH-1:0]       cnt_d   [N_CH];
    logic [N_CH-1:0]        to_d;
    logic [N_CH-1:0]        ek_d;
    logic [N_CH-1:0]        bite_c;
    logic [PRESCALE_W-1:0]  psc_q;
    logic                   tick_c;

    // Shared prescaler: a value above prescale simply wraps round before matching.
    assign tick_c = (psc_q == prescale);

    always_ff @(posedge clk) begin
        if (reset) begin
            psc_q <= '0;
        end else if (tick_c) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_q + PRESCALE_W'(1);
        end
    end

    // Per-channel next state; priority stop > start > kick > tick.
    always_comb begin
        bite_c = '0;
        to_d   = '0;
        ek_d   = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            to_d[i]    = timeout[i] & ~timeout_clr[i];
            ek_d[i]    = early_kick[i];

            if (stop[i]) begin
                state_d[i] = S_IDLE;
                cnt_d[i]   = preload[i*WIDTH +: WIDTH];
                to_d[i]    = 1'b0;
                ek_d[i]    = 1'b0;
            end else if (start[i]) begin
                state_d[i] = S_RUN;
                cnt_d[i]   = preload[i*WIDTH +: WIDTH];
                to_d[i]    = 1'b0;
                ek_d[i]    = 1'b0;
            end else if (kick[i] && (state_q[i] == S_RUN)) begin
                cnt_d[i] = preload[i*WIDTH +: WIDTH];
                if (win_en[i] && (cnt_q[i] < window[i*WIDTH +: WIDTH])) begin
                    ek_d[i]   = 1'b1;
                    bite_c[i] = 1'b1;
                end
            end else if (tick_c && (state_q[i] == S_RUN)) begin
                if (cnt_q[i] == load[i*WIDTH +: WIDTH]) begin
                    to_d[i] = 1'b1;
                    if (auto_reload[i]) begin
                        cnt_d[i]  = preload[i*WIDTH +: WIDTH];
                        // A second timeout without an intervening clear is a bite.
                        bite_c[i] = timeout[i];
                    end else begin
                        state_d[i] = S_EXPIRED;
                        bite_c[i]  = 1'b1;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end
            timeout       <= '0;
            early_kick    <= '0;
            running       <= '0;
            sys_reset_req <= 1'b0;
        end else begin
            for (int i = 0; i < int'(N_CH); i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                running[i] <= (state_d[i] == S_RUN);
            end
            timeout       <= to_d;
            early_kick    <= ek_d;
            sys_reset_req <= sys_reset_req | (|bite_c);
        end
    end

    for (genvar gi = 0; gi < int'(N_CH); gi++) begin : g_count
        assign count[gi*WIDTH +: WIDTH] = cnt_q[gi];
    end

endmodule

// File: tb/tb_watchdog_timer_multi.sv
// Self-checking bench for watchdog_timer_multi: directed scenarios plus random
// traffic, all compared every cycle against a behavioural model.
module tb_watchdog_timer_multi;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 2;
    localparam int unsigned PW = 8;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_EXP  = 2;

    logic            clk;
    logic            reset;
    logic [N-1:0]    start, stop, kick, win_en, auto_reload, timeout_clr;
    logic [N*W-1:0]  load, preload, window;
    logic [PW-1:0]   prescale;
    logic [N-1:0]    timeout, early_kick, running;
    logic [N*W-1:0]  count;
    logic            sys_reset_req;

    int vectors;
    int miscompares;

    // Behavioural model state
    int          m_st  [N];
    logic [W-1:0] m_cnt [N];
    bit          m_to  [N];
    bit          m_ek  [N];
    bit          m_sys;
    int          m_psc;

    watchdog_timer_multi #(.WIDTH(W), .N_CH(N), .PRESCALE_W(PW)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .kick(kick),
        .load(load), .preload(preload), .window(window), .win_en(win_en),
        .auto_reload(auto_reload), .prescale(prescale), .timeout_clr(timeout_clr),
        .timeout(timeout), .early_kick(early_kick), .running(running),
        .count(count), .sys_reset_req(sys_reset_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply the rules of one clock edge to the model, using the sampled inputs.
    task automatic model_step();
        bit tick;
        bit old_to;
        if (reset) begin
            for (int c = 0; c < int'(N); c++) begin
                m_st[c] = M_IDLE; m_cnt[c] = '0; m_to[c] = 0; m_ek[c] = 0;
            end
            m_sys = 0;
            m_psc = 0;
            return;
        end
        tick  = (m_psc == int'(prescale));
        m_psc = tick ? 0 : (m_psc + 1) % (1 << PW);
        for (int c = 0; c < int'(N); c++) begin
            if (stop[c]) begin
                m_st[c] = M_IDLE; m_cnt[c] = preload[c*W +: W]; m_to[c] = 0; m_ek[c] = 0;
            end else if (start[c]) begin
                m_st[c] = M_RUN; m_cnt[c] = preload[c*W +: W]; m_to[c] = 0; m_ek[c] = 0;
            end else begin
                old_to = m_to[c];
                if (timeout_clr[c]) m_to[c] = 0;
                if (kick[c] && m_st[c] == M_RUN) begin
                    if (win_en[c] && m_cnt[c] < window[c*W +: W]) begin
                        m_ek[c] = 1;
                        m_sys   = 1;
                    end
                    m_cnt[c] = preload[c*W +: W];
                end else if (tick && m_st[c] == M_RUN) begin
                    if (m_cnt[c] == load[c*W +: W]) begin
                        m_to[c] = 1;
                        if (auto_reload[c]) begin
                            m_cnt[c] = preload[c*W +: W];
                            if (old_to) m_sys = 1;
                        end else begin
                            m_st[c] = M_EXP;
                            m_sys   = 1;
                        end
                    end else begin
                        m_cnt[c] = m_cnt[c] + 1;
                    end
                end
            end
        end
    endtask

    task automatic compare_model();
        for (int c = 0; c < int'(N); c++) begin
            chk($sformatf("timeout[%0d]", c), 64'(timeout[c]), 64'(m_to[c]));
            chk($sformatf("early_kick[%0d]", c), 64'(early_kick[c]), 64'(m_ek[c]));
            chk($sformatf("running[%0d]", c), 64'(running[c]), 64'(m_st[c] == M_RUN));
            chk($sformatf("count[%0d]", c), 64'(count[c*W +: W]), 64'(m_cnt[c]));
        end
        chk("sys_reset_req", 64'(sys_reset_req), 64'(m_sys));
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic clear_strobes();
        start = '0; stop = '0; kick = '0; timeout_clr = '0;
    endtask

    task automatic set_ch(input int c, input logic [W-1:0] pre, input logic [W-1:0] ld,
                          input logic [W-1:0] win);
        preload[c*W +: W] = pre;
        load[c*W +: W]    = ld;
        window[c*W +: W]  = win;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        clear_strobes();
        load = '0; preload = '0; window = '0; win_en = '0; auto_reload = '0;
        prescale = '0;
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_running", 64'(running), 64'd0);
        chk("reset_sys", 64'(sys_reset_req), 64'd0);

        // Basic one-shot
        set_ch(0, 32'd0, 32'd3, 32'd0);
        start[0] = 1'b1;
        cycle();
        clear_strobes();
        repeat (3) cycle();
        chk("oneshot_cnt3", 64'(count[31:0]), 64'd3);
        chk("oneshot_to_early", 64'(timeout[0]), 64'd0);
        cycle();
        chk("oneshot_timeout", 64'(timeout[0]), 64'd1);
        chk("oneshot_sys", 64'(sys_reset_req), 64'd1);
        chk("oneshot_running", 64'(running[0]), 64'd0);
        cycle();
        chk("oneshot_hold", 64'(count[31:0]), 64'd3);

        // Kick service
        do_reset();
        set_ch(0, 32'd0, 32'd10, 32'd0);
        start[0] = 1'b1;
        cycle();
        clear_strobes();
        for (int k = 0; k < 50; k++) begin
            kick[0] = (k % 5 == 4);
            cycle();
            chk("kick_cnt_le5", 64'(count[31:0] <= 32'd5), 64'd1);
        end
        clear_strobes();
        chk("kick_no_timeout", 64'(timeout[0]), 64'd0);
        chk("kick_no_sys", 64'(sys_reset_req), 64'd0);

        // Window violation
        do_reset();
        set_ch(1, 32'd0, 32'd20, 32'd4);
        win_en[1] = 1'b1;
        start[1]  = 1'b1;
        cycle();
        clear_strobes();
        cycle();
        cycle();
        chk("win_cnt2", 64'(count[63:32]), 64'd2);
        kick[1] = 1'b1;
        cycle();
        clear_strobes();
        chk("win_early", 64'(early_kick[1]), 64'd1);
        chk("win_sys", 64'(sys_reset_req), 64'd1);
        chk("win_reload", 64'(count[63:32]), 64'd0);
        stop[1] = 1'b1;
        cycle();
        clear_strobes();
        chk("win_stop_clr", 64'(early_kick[1]), 64'd0);
        chk("win_sys_sticky", 64'(sys_reset_req), 64'd1);
        win_en = '0;

        // Auto-reload, no clear between events
        prescale = 8'd3;
        do_reset();
        set_ch(0, 32'd0, 32'd2, 32'd0);
        auto_reload[0] = 1'b1;
        start[0] = 1'b1;
        cycle();
        clear_strobes();
        repeat (10) cycle();
        chk("ar_to_before", 64'(timeout[0]), 64'd0);
        cycle();
        chk("ar_to_first", 64'(timeout[0]), 64'd1);
        chk("ar_reload", 64'(count[31:0]), 64'd0);
        chk("ar_running", 64'(running[0]), 64'd1);
        chk("ar_sys_first", 64'(sys_reset_req), 64'd0);
        repeat (11) cycle();
        chk("ar_sys_pre2", 64'(sys_reset_req), 64'd0);
        cycle();
        chk("ar_sys_double", 64'(sys_reset_req), 64'd1);

        // Auto-reload with a clear between events
        do_reset();
        start[0] = 1'b1;
        cycle();
        clear_strobes();
        repeat (14) cycle();
        timeout_clr[0] = 1'b1;
        cycle();
        clear_strobes();
        chk("ar_clr", 64'(timeout[0]), 64'd0);
        repeat (8) cycle();
        chk("ar_clr_to2", 64'(timeout[0]), 64'd1);
        chk("ar_clr_sys", 64'(sys_reset_req), 64'd0);

        // Wrap through all-ones
        prescale = 8'd0;
        auto_reload = '0;
        do_reset();
        set_ch(0, 32'hFFFF_FFFE, 32'd1, 32'd0);
        start[0] = 1'b1;
        cycle();
        clear_strobes();
        chk("wrap_pre", 64'(count[31:0]), 64'hFFFF_FFFE);
        cycle();
        chk("wrap_ones", 64'(count[31:0]), 64'hFFFF_FFFF);
        cycle();
        chk("wrap_zero", 64'(count[31:0]), 64'd0);
        cycle();
        chk("wrap_one", 64'(count[31:0]), 64'd1);
        cycle();
        chk("wrap_timeout", 64'(timeout[0]), 64'd1);

        // start and stop together
        set_ch(1, 32'd5, 32'd9, 32'd0);
        start[1] = 1'b1;
        stop[1]  = 1'b1;
        cycle();
        clear_strobes();
        chk("ss_running", 64'(running[1]), 64'd0);
        chk("ss_count", 64'(count[63:32]), 64'd5);

        // timeout_clr coincident with a timeout event
        do_reset();
        set_ch(0, 32'd0, 32'd1, 32'd0);
        auto_reload[0] = 1'b1;
        start[0] = 1'b1;
        cycle();
        clear_strobes();
        cycle();
        timeout_clr[0] = 1'b1;
        cycle();
        clear_strobes();
        chk("clr_vs_event", 64'(timeout[0]), 64'd1);
        chk("clr_vs_event_sys", 64'(sys_reset_req), 64'd0);
        auto_reload = '0;

        // Mid-operation reset
        do_reset();
        set_ch(0, 32'd0, 32'd100, 32'd0);
        set_ch(1, 32'd0, 32'd1, 32'd0);
        start = 2'b11;
        cycle();
        clear_strobes();
        repeat (7) cycle();
        chk("mid_cnt7", 64'(count[31:0]), 64'd7);
        chk("mid_ch1_exp", 64'(running[1]), 64'd0);
        chk("mid_ch1_to", 64'(timeout[1]), 64'd1);
        prescale = 8'd2;
        do_reset();
        chk("mid_count0", 64'(count), 64'd0);
        chk("mid_to0", 64'(timeout), 64'd0);
        chk("mid_run0", 64'(running), 64'd0);
        chk("mid_sys0", 64'(sys_reset_req), 64'd0);
        start[0] = 1'b1;
        cycle();
        clear_strobes();
        cycle();
        chk("mid_psc_notick", 64'(count[31:0]), 64'd0);
        cycle();
        chk("mid_psc_tick", 64'(count[31:0]), 64'd1);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom % 300 == 0);
            for (int c = 0; c < int'(N); c++) begin
                start[c]       = ($urandom % 40 == 0);
                stop[c]        = ($urandom % 70 == 0);
                kick[c]        = ($urandom % 8 == 0);
                timeout_clr[c] = ($urandom % 20 == 0);
                if ($urandom % 50 == 0) begin
                    if ($urandom % 4 == 0)
                        set_ch(c, 32'hFFFF_FFF0 + 32'($urandom % 16), 32'($urandom % 16),
                               32'($urandom % 8));
                    else
                        set_ch(c, 32'($urandom % 8), 32'($urandom % 16), 32'($urandom % 8));
                    win_en[c]      = ($urandom % 2 == 0);
                    auto_reload[c] = ($urandom % 2 == 0);
                end
            end
            if ($urandom % 100 == 0) prescale = PW'($urandom % 4);
            cycle();
        end
        clear_strobes();
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
